// File: rtl/sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_bridge_pkg
//   Shared definitions for the byte-serial SRAM bridge:
//   - state_e      : controller states
//   - CMD_WR_BIT   : command bit selecting write (1) or read (0)
//   - CMD_ADDR_LSB : lowest bit of the address field in the command byte
// -----------------------------------------------------------------------------
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WR       = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    SEND     = 3'd5
  } state_e;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;

endpackage

// File: rtl/sram_byte_bridge.sv
// -----------------------------------------------------------------------------
// sram_byte_bridge
//   Byte-serial front end for port 0 of an OpenRAM single-clock macro.
//   Command bytes and write data arrive on a valid/ready byte stream; words are
//   assembled least-significant byte first, written or read through the macro
//   pins, and read words are returned as a byte stream, LSB first.
//
// Ports:
//   clk, rst_n             clock (also the macro clk0) and async active-low reset
//   in_data/valid/ready    command and write-data byte stream (sink)
//   out_data/valid/ready   read-data byte stream (source)
//   busy                   high whenever the controller is not in IDLE
//   sram_csb0/web0         macro chip select / write enable, active-low, registered
//   sram_addr0/din0        macro address / write data, registered, held when idle
//   sram_dout0             macro read data
// -----------------------------------------------------------------------------
module sram_byte_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  state_e                state_q,    state_d;
  logic [DATA_WIDTH-1:0] word_q,     word_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                  csb_q,      csb_d;
  logic                  web_q,      web_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] din_q,      din_d;

  logic cnt_last;

  assign in_ready  = (state_q == IDLE) || (state_q == GET_DATA);
  assign out_valid = (state_q == SEND);
  assign out_data  = word_q[7:0];
  assign busy      = (state_q != IDLE);
  assign cnt_last  = (cnt_q == CNT_LAST);

  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    cmd_addr_d = cmd_addr_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cmd_addr_d = in_data[CMD_ADDR_LSB +: ADDR_WIDTH];
          state_d    = in_data[CMD_WR_BIT] ? GET_DATA : RD_REQ;
        end
      end

      GET_DATA: begin
        if (in_valid) begin
          // New byte enters at the top so the first byte ends up in the LSBs.
          word_d = (word_q >> 8) | (DATA_WIDTH'(in_data) << (DATA_WIDTH - 8));
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = WR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR:      state_d = IDLE;

      RD_REQ:  state_d = RD_WAIT;

      RD_WAIT: begin
        // The macro drives dout during this cycle; capture on its closing edge.
        word_d  = sram_dout0;
        state_d = SEND;
      end

      SEND: begin
        if (out_ready) begin
          word_d = word_q >> 8;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Macro pins are decoded from the next state so they come straight from
    // flops and line up with the cycle spent in WR or RD_REQ.
    csb_d  = !((state_d == WR) || (state_d == RD_REQ));
    web_d  = (state_d != WR);
    addr_d = csb_d ? addr_q : cmd_addr_d;
    din_d  = (state_d == WR) ? word_d : din_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      cmd_addr_q <= '0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      cmd_addr_q <= cmd_addr_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

endmodule

// File: tb/tb_sram_byte_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_byte_bridge
//   Directed and randomized bench for sram_byte_bridge. A behavioural macro
//   model sits on the SRAM pins; ref_mem holds the contents the byte protocol
//   should have produced, and every readback is compared against it.
// -----------------------------------------------------------------------------
module tb_sram_byte_bridge;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BYTES = DW / 8;
  localparam int LIMIT = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_byte_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // Macro model and expected contents.
  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  logic          preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    end else if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0      <= mem[sram_addr0];
    end
  end

  // Edge counter and macro-select monitor. csb_edge is the edge that closes
  // the cycle in which the select was low.
  int            cyc        = 0;
  int            csb_pulses = 0;
  int            csb_edge   = -1;
  logic          csb_web;
  logic [AW-1:0] csb_addr;
  logic [DW-1:0] csb_din;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sram_csb0) begin
      csb_pulses <= csb_pulses + 1;
      csb_edge   <= cyc + 1;
      csb_web    <= sram_web0;
      csb_addr   <= sram_addr0;
      csb_din    <= sram_din0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time observed %0t required below 400000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b, input bit hold, output int edge_o);
    int k;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (k >= LIMIT) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    edge_o = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] cmd, input logic [DW-1:0] data, input bit hold,
                            output int cmd_edge, output int last_edge);
    send_byte(cmd, hold, cmd_edge);
    for (int i = 0; i < BYTES; i++) send_byte(data[8*i +: 8], hold, last_edge);
    ref_mem[cmd[AW-1:0]] = data;
  endtask

  // Collect one response word; 'stall' cycles of out_ready low before each byte.
  task automatic recv_word(input int stall, output logic [DW-1:0] w, output int first_edge);
    int k;
    logic [7:0] held;
    w = '0;
    first_edge = -1;
    for (int i = 0; i < BYTES; i++) begin
      @(negedge clk);
      k = 0;
      while (!out_valid && k < LIMIT) begin
        @(negedge clk);
        k++;
      end
      if (k >= LIMIT) check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
      if (i == 0) first_edge = cyc + 1;
      if (stall > 0) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("bp_valid", {31'b0, out_valid}, 32'd1);
          check("bp_data", {24'b0, out_data}, {24'b0, held});
        end
      end
      out_ready = 1'b1;
      w[8*i +: 8] = out_data;
      @(posedge clk);
      #1;
      out_ready = (stall == 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic read_word(input logic [7:0] cmd, input int stall, output logic [DW-1:0] w,
                           output int cmd_edge, output int first_edge);
    send_byte(cmd, 1'b0, cmd_edge);
    recv_word(stall, w, first_edge);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb"},      {31'b0, sram_csb0},  32'd1);
    check({tag, "_web"},      {31'b0, sram_web0},  32'd1);
    check({tag, "_addr"},     {28'b0, sram_addr0}, 32'd0);
    check({tag, "_din"},      sram_din0,           32'd0);
    check({tag, "_outvalid"}, {31'b0, out_valid},  32'd0);
    check({tag, "_outdata"},  {24'b0, out_data},   32'd0);
    check({tag, "_busy"},     {31'b0, busy},       32'd0);
    check({tag, "_inready"},  {31'b0, in_ready},   32'd1);
  endtask

  initial begin
    int ce, le, fv, ce2, p;
    logic [DW-1:0] w, d;
    logic [AW-1:0] a;
    logic [7:0] res;
    int stall;

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;

    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write 0xDEADBEEF to address 5.
    p = csb_pulses;
    write_word(8'h85, 32'hDEADBEEF, 1'b0, ce, le);
    @(posedge clk);
    #1;
    check("wr_csb_edge", csb_edge, le + 1);
    check("wr_web",      {31'b0, csb_web}, 32'd0);
    check("wr_addr",     {28'b0, csb_addr}, 32'd5);
    check("wr_din",      csb_din, 32'hDEADBEEF);
    check("wr_pulses",   csb_pulses, p + 1);
    @(negedge clk);
    check("wr_busy_after", {31'b0, busy}, 32'd0);

    // Read it back.
    p = csb_pulses;
    read_word(8'h05, 0, w, ce, fv);
    check("rd_data",     w, ref_mem[5]);
    check("rd_latency",  fv - ce, 32'd3);
    check("rd_csb_edge", csb_edge, ce + 1);
    check("rd_web",      {31'b0, csb_web}, 32'd1);
    check("rd_addr",     {28'b0, csb_addr}, 32'd5);
    check("rd_pulses",   csb_pulses, p + 1);

    // Backpressure: four stalled cycles before every byte.
    p = csb_pulses;
    read_word(8'h05, 4, w, ce, fv);
    check("bp_word",   w, 32'hDEADBEEF);
    check("bp_pulses", csb_pulses, p + 1);

    // Reserved command bits are ignored.
    write_word(8'hF3, 32'h04030201, 1'b0, ce, le);
    @(posedge clk);
    #1;
    check("res_addr", {28'b0, csb_addr}, 32'd3);
    check("res_din",  csb_din, 32'h04030201);
    read_word(8'h73, 0, w, ce, fv);
    check("res_read", w, 32'h04030201);

    // Reset after two data bytes of a write to address 0.
    p = csb_pulses;
    send_byte(8'h80, 1'b0, ce);
    send_byte(8'h11, 1'b0, le);
    send_byte(8'h22, 1'b0, le);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wr");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_pulses", csb_pulses, p);
    read_word(8'h00, 0, w, ce, fv);
    check("rst_wr_read", w, ref_mem[0]);

    // Reset while the macro is selected for a read.
    p = csb_pulses;
    send_byte(8'h02, 1'b0, ce);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_rd_csb", {31'b0, sram_csb0}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rd_pulses", csb_pulses, p);
    check("rst_rd_outvalid", {31'b0, out_valid}, 32'd0);
    check("rst_rd_busy", {31'b0, busy}, 32'd0);

    // Back-to-back write then read of address 15, then another read.
    d = $urandom;
    write_word(8'h8F, d, 1'b1, ce, le);
    read_word(8'h0F, 0, w, ce2, fv);
    check("b2b_wr_spacing", ce2 - ce, BYTES + 2);
    check("b2b_data", w, d);
    check("b2b_din_hold", sram_din0, d);
    read_word(8'h0F, 0, w, ce, fv);
    check("b2b_rd_spacing", ce - ce2, BYTES + 3);
    check("b2b_data2", w, d);

    // Randomized traffic against the reference contents.
    for (int n = 0; n < 30; n++) begin
      a     = AW'($urandom_range(0, 15));
      res   = 8'($urandom_range(0, 7) << 4);
      stall = $urandom_range(0, 2);
      p     = csb_pulses;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        write_word(8'h80 | res | {4'b0, a}, d, 1'b0, ce, le);
      end else begin
        read_word(res | {4'b0, a}, stall, w, ce, fv);
        check("rand_read", w, ref_mem[a]);
      end
      @(posedge clk);
      #1;
      check("rand_pulses", csb_pulses, p + 1);
    end

    // Sweep every address once so the final contents are all confirmed.
    for (int i = 0; i < 16; i++) begin
      read_word(8'(i), 0, w, ce, fv);
      check("sweep_read", w, ref_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
